parity_engine: RTL and testbench

- Parametrised, multi-cycle parity generator/checker. Replaces the fixed 8-bit start/busy parity unit.
- Accumulates parity over a frame of 1..2^LEN_W-1 words, each DATA_W bits wide, processing BITS_PER_CYCLE bits per clock.
- Optionally checks the result against an expected parity bit.
- Sits between a word source, which uses a valid/ready handshake, and a control FSM, which uses start/busy/done.

---
 rtl/parity_engine_if.sv | 30 +++
 rtl/parity_engine.sv | 125 ++++++++++++
 tb/tb_parity_engine.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_engine_if.sv
// Word-source / control-FSM bus for parity_engine: valid/ready data path plus
// start/busy/done control and the registered parity results.
interface parity_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
);
  logic              start;
  logic [LEN_W-1:0]  frame_len;
  logic              check_en;
  logic              mode;
  logic              exp_parity;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic              done;
  logic              even_parity;
  logic              odd_parity;
  logic              parity_err;

  modport master (
    output start, frame_len, check_en, mode, exp_parity, data_in, data_valid,
    input  data_ready, busy, done, even_parity, odd_parity, parity_err
  );

  modport slave (
    input  start, frame_len, check_en, mode, exp_parity, data_in, data_valid,
    output data_ready, busy, done, even_parity, odd_parity, parity_err
  );
endinterface

// File: rtl/parity_engine.sv
// Multi-cycle parity generator/checker: folds BITS_PER_CYCLE bits per clock over
// a frame of frame_len words and optionally checks against an expected bit.
module parity_engine #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned LEN_W          = 4
) (
  input logic           clk,
  input logic           rst_n,
  parity_engine_if.slave pif
);

  localparam int unsigned SHIFTS = DATA_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SHIFTS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              acc_q, acc_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic              chk_q, chk_d;
  logic              mode_q, mode_d;
  logic              exp_q, exp_d;
  logic              even_q, even_d;
  logic              odd_q, odd_d;
  logic              err_q, err_d;
  logic              acc_next;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    shreg_d  = shreg_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    chk_d    = chk_q;
    mode_d   = mode_q;
    exp_d    = exp_q;
    even_d   = even_q;
    odd_d    = odd_q;
    err_d    = err_q;
    acc_next = acc_q ^ (^shreg_q[BITS_PER_CYCLE-1:0]);

    case (state_q)
      IDLE: begin
        if (pif.start && (pif.frame_len != '0)) begin
          state_d = LOAD;
          wcnt_d  = pif.frame_len;
          chk_d   = pif.check_en;
          mode_d  = pif.mode;
          exp_d   = pif.exp_parity;
          acc_d   = 1'b0;
        end
      end
      LOAD: begin
        if (pif.data_valid) begin
          shreg_d = pif.data_in;
          bcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = acc_next;
        shreg_d = shreg_q >> BITS_PER_CYCLE;
        bcnt_d  = bcnt_q + 1'b1;
        if (bcnt_q == LAST_BIT) begin
          bcnt_d = '0;
          wcnt_d = wcnt_q - 1'b1;
          // Results are latched on the way into DONE so they hold until the next frame.
          if (wcnt_q == LEN_W'(1)) begin
            state_d = DONE;
            even_d  = acc_next;
            odd_d   = ~acc_next;
            err_d   = chk_q & ((mode_q ? ~acc_next : acc_next) != exp_q);
          end else begin
            state_d = LOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      shreg_q <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      chk_q   <= 1'b0;
      mode_q  <= 1'b0;
      exp_q   <= 1'b0;
      even_q  <= 1'b0;
      odd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      chk_q   <= chk_d;
      mode_q  <= mode_d;
      exp_q   <= exp_d;
      even_q  <= even_d;
      odd_q   <= odd_d;
      err_q   <= err_d;
    end
  end

  assign pif.data_ready  = (state_q == LOAD);
  assign pif.busy        = (state_q != IDLE);
  assign pif.done        = (state_q == DONE);
  assign pif.even_parity = even_q;
  assign pif.odd_parity  = odd_q;
  assign pif.parity_err  = err_q;

endmodule

// File: tb/tb_parity_engine.sv
// Bench for parity_engine: a BITS_PER_CYCLE=1 and a BITS_PER_CYCLE=4 build share
// one stimulus stream and are both compared every cycle against a word-level model.
module tb_parity_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] frame_len = '0;
  logic       check_en = 1'b0;
  logic       mode = 1'b0;
  logic       exp_parity = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt1 = 0;

  always #5 clk = ~clk;

  parity_engine_if #(.DATA_W(8), .LEN_W(4)) if1 ();
  parity_engine_if #(.DATA_W(8), .LEN_W(4)) if4 ();

  assign if1.start = start;      assign if4.start = start;
  assign if1.frame_len = frame_len;  assign if4.frame_len = frame_len;
  assign if1.check_en = check_en;    assign if4.check_en = check_en;
  assign if1.mode = mode;            assign if4.mode = mode;
  assign if1.exp_parity = exp_parity; assign if4.exp_parity = exp_parity;
  assign if1.data_in = data_in;      assign if4.data_in = data_in;
  assign if1.data_valid = data_valid; assign if4.data_valid = data_valid;

  parity_engine #(.DATA_W(8), .BITS_PER_CYCLE(1), .LEN_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pif(if1.slave));
  parity_engine #(.DATA_W(8), .BITS_PER_CYCLE(4), .LEN_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .pif(if4.slave));

  logic [1:0] busy_v, ready_v, done_v, even_v, odd_v, err_v;
  assign busy_v  = {if4.busy, if1.busy};
  assign ready_v = {if4.data_ready, if1.data_ready};
  assign done_v  = {if4.done, if1.done};
  assign even_v  = {if4.even_parity, if1.even_parity};
  assign odd_v   = {if4.odd_parity, if1.odd_parity};
  assign err_v   = {if4.parity_err, if1.parity_err};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level model: a frame's parity is the XOR of each accepted word's reduction.
  typedef struct packed {
    logic       busy;
    logic       waitw;
    logic       done;
    logic       acc;
    logic       even;
    logic       odd;
    logic       err;
    logic       ce;
    logic       md;
    logic       ex;
    logic [7:0] left;
    logic [4:0] words;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t step(input mdl_t s, input int unsigned shifts);
    mdl_t n = s;
    if (s.done) begin
      n.done = 1'b0;
      n.busy = 1'b0;
    end else if (!s.busy) begin
      if (start && frame_len != 4'd0) begin
        n.busy = 1'b1; n.waitw = 1'b1; n.words = {1'b0, frame_len};
        n.ce = check_en; n.md = mode; n.ex = exp_parity; n.acc = 1'b0;
      end
    end else if (s.waitw) begin
      if (data_valid) begin
        n.waitw = 1'b0;
        n.acc   = s.acc ^ (^data_in);
        n.left  = 8'(shifts);
      end
    end else begin
      n.left = s.left - 8'd1;
      if (n.left == 8'd0) begin
        n.words = s.words - 5'd1;
        if (n.words == 5'd0) begin
          n.done = 1'b1;
          n.even = s.acc;
          n.odd  = ~s.acc;
          n.err  = s.ce & ((s.md ? ~s.acc : s.acc) != s.ex);
        end else begin
          n.waitw = 1'b1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= '0;
      m[1] <= '0;
    end else begin
      m[0] <= step(m[0], 8);
      m[1] <= step(m[1], 2);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cyc_busy%0d", i),  busy_v[i],  m[i].busy);
      check($sformatf("cyc_ready%0d", i), ready_v[i], m[i].busy & m[i].waitw);
      check($sformatf("cyc_done%0d", i),  done_v[i],  m[i].done);
      check($sformatf("cyc_even%0d", i),  even_v[i],  m[i].even);
      check($sformatf("cyc_odd%0d", i),   odd_v[i],   m[i].odd);
      check($sformatf("cyc_err%0d", i),   err_v[i],   m[i].err);
    end
    if (if1.done) done_cnt1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [3:0] len, input logic ce, input logic md,
                             input logic ex);
    frame_len = len; check_en = ce; mode = md; exp_parity = ex;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n counts cycles with the start cycle as 0; returns first done cycle of each build.
  task automatic run_until_idle(input int n0, output int n_end, output int n1, output int n4);
    int n = n0;
    n1 = -1;
    n4 = -1;
    while ((if1.busy || if4.busy) && n < 400) begin
      tick();
      n++;
      if (if1.done && n1 < 0) n1 = n;
      if (if4.done && n4 < 0) n4 = n;
    end
    check("idle_timeout", (n < 400), 1);
    n_end = n;
  endtask

  initial begin
    int ne, n1, n4, n, k, dc;
    logic [7:0] words [3];
    words[0] = 8'h01; words[1] = 8'h03; words[2] = 8'h07;

    #2;
    check("rst_busy", if1.busy, 0);
    check("rst_ready", if1.data_ready, 0);
    check("rst_done", if1.done, 0);
    check("rst_even", if1.even_parity, 0);
    check("rst_odd", if1.odd_parity, 0);
    check("rst_err", if1.parity_err, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single word A5 with data_valid held high.
    data_in = 8'hA5; data_valid = 1'b1;
    start_frame(4'd1, 1'b0, 1'b0, 1'b0);
    check("t1_ready_c1", if1.data_ready, 1);
    run_until_idle(1, ne, n1, n4);
    check("t1_done_cycle", n1, 10);
    check("t1_busy_fall", ne, 11);
    check("t1_even", if1.even_parity, 0);
    check("t1_odd", if1.odd_parity, 1);
    check("t1_err", if1.parity_err, 0);

    // Three words with two idle cycles ahead of each.
    data_valid = 1'b0;
    dc = done_cnt1;
    start_frame(4'd3, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      k = 0;
      while (!if1.data_ready && k < 50) begin tick(); k++; end
      check("t2_ready_timeout", (k < 50), 1);
      tick();
      check("t2_ready_hold", if1.data_ready, 1);
      tick();
      check("t2_ready_hold", if1.data_ready, 1);
      data_in = words[w]; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
    end
    run_until_idle(0, ne, n1, n4);
    check("t2_done_pulses", done_cnt1 - dc, 1);
    check("t2_even", if1.even_parity, 0);
    check("t2_odd", if1.odd_parity, 1);

    // Check mode: odd sense against 8'h01.
    data_in = 8'h01; data_valid = 1'b1;
    start_frame(4'd1, 1'b1, 1'b1, 1'b0);
    run_until_idle(1, ne, n1, n4);
    check("t3a_odd", if1.odd_parity, 0);
    check("t3a_err", if1.parity_err, 0);
    start_frame(4'd1, 1'b1, 1'b1, 1'b1);
    run_until_idle(1, ne, n1, n4);
    check("t3b_err", if1.parity_err, 1);

    // Zero-length request is dropped and leaves results alone.
    frame_len = 4'd0; start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    check("t5_len0_busy", if1.busy, 0);
    check("t5_len0_err", if1.parity_err, 1);
    check("t5_len0_odd", if1.odd_parity, 0);

    start_frame(4'd1, 1'b0, 1'b1, 1'b1);
    run_until_idle(1, ne, n1, n4);
    check("t3c_err", if1.parity_err, 0);

    // 8'hFF: the 4-bit build finishes at cycle 4.
    data_in = 8'hFF;
    start_frame(4'd1, 1'b0, 1'b0, 1'b0);
    run_until_idle(1, ne, n1, n4);
    check("t4_done4_cycle", n4, 4);
    check("t4_even4", if4.even_parity, 0);
    check("t4_odd4", if4.odd_parity, 1);
    check("t4_done1_cycle", n1, 10);
    check("t4_even1", if1.even_parity, 0);

    // start held across the middle of a two-word frame is ignored.
    data_in = 8'h03;
    start_frame(4'd2, 1'b0, 1'b0, 1'b0);
    n = 1;
    while (n < 5) begin tick(); n++; end
    frame_len = 4'd5; check_en = 1'b1; exp_parity = 1'b1; start = 1'b1;
    while (n < 12) begin tick(); n++; end
    start = 1'b0;
    run_until_idle(n, ne, n1, n4);
    check("t5_mid_done_cycle", n1, 19);
    check("t5_mid_even", if1.even_parity, 0);
    check("t5_mid_err", if1.parity_err, 0);

    // Maximum frame: 15 words of 8'h80.
    data_in = 8'h80;
    start_frame(4'd15, 1'b0, 1'b0, 1'b0);
    run_until_idle(1, ne, n1, n4);
    check("t5_max_done1", n1, 136);
    check("t5_max_done4", n4, 46);
    check("t5_max_even", if1.even_parity, 1);
    check("t5_max_odd", if1.odd_parity, 0);

    // Reset during the second word's SHIFT of a three-word frame.
    data_in = 8'hFF;
    start_frame(4'd3, 1'b0, 1'b0, 1'b0);
    n = 1;
    while (n < 13) begin tick(); n++; end
    check("t6_busy_before", if1.busy, 1);
    dc = done_cnt1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", if1.busy, 0);
    check("t6_rst_ready", if1.data_ready, 0);
    check("t6_rst_done", if1.done, 0);
    check("t6_rst_even", if1.even_parity, 0);
    check("t6_rst_odd", if1.odd_parity, 0);
    check("t6_rst_err", if1.parity_err, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("t6_no_done", done_cnt1 - dc, 0);
    data_in = 8'h01;
    start_frame(4'd1, 1'b1, 1'b0, 1'b1);
    run_until_idle(1, ne, n1, n4);
    check("t6_new_done", n1, 10);
    check("t6_new_even", if1.even_parity, 1);
    check("t6_new_odd", if1.odd_parity, 0);
    check("t6_new_err", if1.parity_err, 0);

    data_valid = 1'b0;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1);
  end

endmodule
